// File: rtl/payment_controller.sv
// payment_controller
// Collects coins against a latched product price, then either dispenses and
// pays change or refunds the credit on cancel or on inactivity timeout.
// Each transaction is closed with a one-cycle timeout_flag pulse, which
// returns the upstream product selector to idle.
module payment_controller #(
  parameter int TIMEOUT_CYCLES = 100,
  parameter int TIMER_W        = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       product_selector_done,
  input  logic [1:0] product_out,
  input  logic [4:0] product_price,
  input  logic       coin_valid,
  input  logic [1:0] coin_value,
  input  logic       cancel,
  output logic       timeout_flag,
  output logic [5:0] credit,
  output logic       dispense_valid,
  output logic [1:0] dispense_product,
  output logic       change_valid,
  output logic [5:0] change_amount,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COLLECT  = 3'd1,
    DISPENSE = 3'd2,
    FINISH   = 3'd3,
    REFUND   = 3'd4
  } state_t;

  // Timer value on which a coin-free COLLECT cycle ends the transaction.
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_ONE  = TIMER_W'(1);

  state_t             state;
  state_t             state_nxt;
  logic [5:0]         credit_q;
  logic [5:0]         credit_nxt;
  logic [TIMER_W-1:0] timer_q;
  logic [TIMER_W-1:0] timer_nxt;
  logic               latch_sel;

  // Selection is plain data: it is only ever observed while the FSM is
  // outside IDLE, so it carries no reset.
  logic [1:0]         product_q;
  logic [4:0]         price_q;

  logic [5:0]         change_amt;

  // Coin code to unit value.
  function automatic logic [5:0] coin_units(input logic [1:0] code);
    logic [5:0] units;
    unique case (code)
      2'b00:   units = 6'd1;
      2'b01:   units = 6'd2;
      2'b10:   units = 6'd5;
      default: units = 6'd10;
    endcase
    return units;
  endfunction

  // Control state: FSM, credit and inactivity timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      credit_q <= '0;
      timer_q  <= '0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
      timer_q  <= timer_nxt;
    end
  end

  // Capture the product code and price when a valid selection is accepted.
  always_ff @(posedge clk) begin
    if (latch_sel) begin
      product_q <= product_out;
      price_q   <= product_price;
    end
  end

  // Next-state, credit accumulation and timer update.
  always_comb begin
    state_nxt  = state;
    credit_nxt = credit_q;
    timer_nxt  = timer_q;
    latch_sel  = 1'b0;
    unique case (state)
      IDLE: begin
        // Coins in IDLE are ignored; an invalid selection still closes the
        // handshake through a zero-value REFUND.
        if (product_selector_done) begin
          if (product_out != 2'b00) begin
            latch_sel = 1'b1;
            timer_nxt = '0;
            state_nxt = COLLECT;
          end else begin
            state_nxt = REFUND;
          end
        end
      end
      COLLECT: begin
        // A coin is always credited, even in a cancel cycle, so it ends up
        // in the refund.
        if (coin_valid) begin
          credit_nxt = credit_q + coin_units(coin_value);
          timer_nxt  = '0;
        end else if (timer_q != TIMER_LAST) begin
          timer_nxt = timer_q + TIMER_ONE;
        end
        // Price check uses registered credit, so the coin that reaches the
        // price is visible one cycle before DISPENSE.
        if (cancel) begin
          state_nxt = REFUND;
        end else if (credit_q >= {1'b0, price_q}) begin
          state_nxt = DISPENSE;
        end else if (!coin_valid && (timer_q == TIMER_LAST)) begin
          state_nxt = REFUND;
        end
      end
      DISPENSE: begin
        state_nxt = FINISH;
      end
      FINISH, REFUND: begin
        credit_nxt = '0;
        state_nxt  = IDLE;
      end
      default: begin
        credit_nxt = '0;
        state_nxt  = IDLE;
      end
    endcase
  end

  // Moore-decoded outputs.
  always_comb begin
    change_amt = '0;
    if (state == FINISH) begin
      change_amt = credit_q - {1'b0, price_q};
    end else if (state == REFUND) begin
      change_amt = credit_q;
    end
    busy             = (state != IDLE);
    timeout_flag     = (state == FINISH) || (state == REFUND);
    dispense_valid   = (state == DISPENSE);
    dispense_product = (state == DISPENSE) ? product_q : 2'b00;
    change_valid     = timeout_flag && (change_amt != 6'd0);
    change_amount    = change_amt;
    credit           = credit_q;
  end

endmodule
